// File: rtl/mainbus_pkg.sv
// Shared types and constants for the main-bus memory controller slice.
package mainbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int BURST_LEN = 4;
  localparam int PAGE_MSB  = 15;
  localparam int PAGE_LSB  = 12;

  typedef logic [3:0]  page_t;
  typedef logic [15:0] word_t;

endpackage

// File: rtl/mainbus_mem_ctrl_if.sv
// Main bus: multiplexed AddrData with one tristate driver per side,
// resolved here so each side only supplies its word and enable.
interface mainbus_mem_ctrl_if;
  import mainbus_pkg::*;

  // Handshake: AddrValid is a one-cycle pulse qualifying an address on AddrData
  // with rw; no ready exists, a responder accepts only when idle and page-matched.
  wire  [15:0] AddrData;
  logic        AddrValid;
  logic        rw;

  word_t       rd_word;
  logic        rd_en;
  word_t       wr_word;
  logic        wr_en;

  assign AddrData = rd_en ? rd_word : 16'bz;
  assign AddrData = wr_en ? wr_word : 16'bz;

  modport slave  (input AddrData, AddrValid, rw, output rd_word, rd_en);
  modport master (input AddrData, rd_en, output AddrValid, rw, wr_word, wr_en);

endinterface

// File: rtl/mainbus_mem_array.sv
// Single-port page storage: synchronous write, combinational read at the same address.
module mainbus_mem_array
  import mainbus_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mainbus_mem_ctrl.sv
// Main-bus responder owning one page; fixed 4-word read/write bursts.
// Optional burst/miss counters enabled by `define MAINBUS_MEM_STATS_EN.
module mainbus_mem_ctrl
  import mainbus_pkg::*;
#(
  parameter page_t PAGE   = 4'h0,
  parameter int    ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetH,
  mainbus_mem_ctrl_if.slave bus,
  output state_t            dbg_state
`ifdef MAINBUS_MEM_STATS_EN
  ,
  output logic [15:0]       rd_bursts,
  output logic [15:0]       wr_bursts,
  output logic [15:0]       page_miss
`endif
);

  state_t            state_q, state_n;
  logic [1:0]        beat_q, beat_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] mem_addr;
  logic              page_hit;
  logic              accept;
  logic              mem_we;
  word_t             mem_rdata;

  assign page_hit = (bus.AddrData[PAGE_MSB:PAGE_LSB] == PAGE);
  assign accept   = (state_q == IDLE) && bus.AddrValid && page_hit;

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      beat_q  <= beat_n;
      addr_q  <= addr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    beat_n  = beat_q;
    addr_n  = addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_n  = bus.AddrData[ADDR_W-1:0];
          beat_n  = 2'd0;
          state_n = bus.rw ? READ : WRITE;
        end
      end
      READ, WRITE: begin
        beat_n = beat_q + 2'd1;
        if (beat_q == 2'(BURST_LEN - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Address wraps inside the page because the sum is truncated to ADDR_W bits.
  assign mem_addr = addr_q + ADDR_W'(beat_q);
  assign mem_we   = (state_q == WRITE);

  mainbus_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.AddrData),
    .rdata (mem_rdata)
  );

  // Drive enable comes straight from the state register, so it cannot glitch.
  assign bus.rd_en   = (state_q == READ);
  assign bus.rd_word = mem_rdata;
  assign dbg_state   = state_q;

`ifdef MAINBUS_MEM_STATS_EN
  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      rd_bursts <= 16'd0;
      wr_bursts <= 16'd0;
      page_miss <= 16'd0;
    end else begin
      if (accept && bus.rw)  rd_bursts <= rd_bursts + 16'd1;
      if (accept && !bus.rw) wr_bursts <= wr_bursts + 16'd1;
      if ((state_q == IDLE) && bus.AddrValid && !page_hit) page_miss <= page_miss + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mainbus_mem_ctrl.sv
// Directed bench for mainbus_mem_ctrl at PAGE=2; optional counters checked
// when MAINBUS_MEM_STATS_EN is defined.
module tb_mainbus_mem_ctrl;
  import mainbus_pkg::*;

  logic   clk = 1'b0;
  logic   resetH;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;
`ifdef MAINBUS_MEM_STATS_EN
  logic [15:0] rd_bursts, wr_bursts, page_miss;
`endif

  mainbus_mem_ctrl_if bus ();

  mainbus_mem_ctrl #(.PAGE(4'h2), .ADDR_W(12)) dut (
    .clk       (clk),
    .resetH    (resetH),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
`ifdef MAINBUS_MEM_STATS_EN
    ,
    .rd_bursts (rd_bursts),
    .wr_bursts (wr_bursts),
    .page_miss (page_miss)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_released(input string tag);
    check({tag, "_drive"}, {15'd0, bus.rd_en}, 16'd0);
    check({tag, "_state"}, 16'(dbg_state), 16'(IDLE));
  endtask

  // Cycle 0: address on the bus with AddrValid.
  task automatic issue(input word_t addr, input logic r);
    @(negedge clk);
    bus.AddrValid = 1'b1;
    bus.rw        = r;
    bus.wr_en     = 1'b1;
    bus.wr_word   = addr;
    #1;
    check("c0_drive", {15'd0, bus.rd_en}, 16'd0);
  endtask

  task automatic write_burst(input word_t addr, input word_t d [4]);
    issue(addr, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.AddrValid = 1'b0;
      bus.wr_word   = d[k];
      #1;
      check("wr_drive", {15'd0, bus.rd_en}, 16'd0);
    end
  endtask

  // Checks the first n beats' data; poke >= 0 raises AddrValid in that beat.
  task automatic read_burst(input word_t addr, input word_t exp [4], input int n, input int poke);
    issue(addr, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.wr_en     = 1'b0;
      bus.rw        = 1'b1;
      bus.AddrValid = (k == poke);
      #1;
      check("rd_drive", {15'd0, bus.rd_en}, 16'd1);
      if (k < n) check("rd_data", bus.AddrData, exp[k]);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.AddrValid = 1'b0;
      bus.wr_en     = 1'b0;
      #1;
      check_released(tag);
    end
  endtask

  initial begin
    resetH        = 1'b1;
    bus.AddrValid = 1'b0;
    bus.rw        = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_word   = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check_released("reset");
`ifdef MAINBUS_MEM_STATS_EN
    check("rst_rd", rd_bursts, 16'd0);
    check("rst_wr", wr_bursts, 16'd0);
    check("rst_miss", page_miss, 16'd0);
`endif
    resetH = 1'b0;

    // Basic write then read.
    write_burst(16'h2010, '{16'hA001, 16'hA002, 16'hA003, 16'hA004});
    read_burst(16'h2010, '{16'hA001, 16'hA002, 16'hA003, 16'hA004}, 4, -1);
    idle_cycles(1, "after_rd");

    // Wrap inside the page.
    write_burst(16'h2FFE, '{16'h1111, 16'h2222, 16'h3333, 16'h4444});
    read_burst(16'h2000, '{16'h3333, 16'h4444, 16'h0000, 16'h0000}, 2, -1);
    read_burst(16'h2FFE, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4, -1);
    idle_cycles(1, "after_wrap");

    // Page miss: bus stays released for cycles 0..6.
    issue(16'h3010, 1'b1);
    idle_cycles(6, "miss");
    read_burst(16'h2010, '{16'hA001, 16'hA002, 16'hA003, 16'hA004}, 4, -1);

    // AddrValid in cycle 2 ignored, then back-to-back read in cycle 5.
    read_burst(16'h2010, '{16'hA001, 16'hA002, 16'hA003, 16'hA004}, 4, 1);
    read_burst(16'h2FFE, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4, -1);
    idle_cycles(2, "after_b2b");

    // Asynchronous reset in cycle 2 of a read.
    issue(16'h2010, 1'b1);
    @(negedge clk);
    bus.AddrValid = 1'b0;
    bus.wr_en     = 1'b0;
    #1;
    check("mid_c1", bus.AddrData, 16'hA001);
    @(negedge clk);
    #1;
    check("mid_c2", bus.AddrData, 16'hA002);
    #2;
    resetH = 1'b1;
    #1;
    check_released("async_rst");
    @(negedge clk);
    resetH = 1'b0;

    write_burst(16'h2020, '{16'hB001, 16'hB002, 16'hB003, 16'hB004});
    read_burst(16'h2020, '{16'hB001, 16'hB002, 16'hB003, 16'hB004}, 4, -1);
    read_burst(16'h2010, '{16'hA001, 16'hA002, 16'hA003, 16'hA004}, 4, -1);
    write_burst(16'h2030, '{16'hC001, 16'hC002, 16'hC003, 16'hC004});
    read_burst(16'h2030, '{16'hC001, 16'hC002, 16'hC003, 16'hC004}, 4, -1);
    issue(16'h3000, 1'b1);
    idle_cycles(2, "miss2");

`ifdef MAINBUS_MEM_STATS_EN
    check("st_rd", rd_bursts, 16'd3);
    check("st_wr", wr_bursts, 16'd2);
    check("st_miss", page_miss, 16'd1);
    resetH = 1'b1;
    #1;
    check("st_rd_rst", rd_bursts, 16'd0);
    check("st_wr_rst", wr_bursts, 16'd0);
    check("st_miss_rst", page_miss, 16'd0);
    @(negedge clk);
    resetH = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
